// File: rtl/font_render_ctrl.sv
// Turns one ASCII code into six font ROM reads, then streams the column bytes and blank gap columns.
// Latency: accept to first col_valid is 3 cycles; each glyph column takes 3 cycles and each gap column 1.
// Backpressure: col_valid/col_data/col_last hold while col_ready=0; char_ready is only high in IDLE.
module font_render_ctrl #(
  parameter logic [7:0] FIRST_CHAR = 8'h20,
  parameter int         NUM_CHARS  = 94,
  parameter int         COLS       = 6,
  parameter int         GAP_COLS   = 1,
  parameter logic [7:0] SUBST_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [9:0] rom_addr,
  output logic       rom_rd,
  input  logic [7:0] rom_data,
  output logic [7:0] col_data,
  output logic       col_valid,
  input  logic       col_ready,
  output logic       col_last,
  output logic       busy
);

  localparam int               CNT_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);
  localparam logic [1:0]       LAST_GAP = 2'(GAP_COLS - 1);
  localparam logic [8:0]       END_CHAR = 9'(int'(FIRST_CHAR) + NUM_CHARS);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic             char_ready_q, char_ready_d;
  logic             rom_rd_q, rom_rd_d;
  logic [9:0]       rom_addr_q, rom_addr_d;
  logic [7:0]       col_data_q, col_data_d;
  logic             col_valid_q, col_valid_d;
  logic             col_last_q, col_last_d;
  logic             busy_q, busy_d;
  logic [9:0]       base_q, base_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [1:0]       gap_cnt_q, gap_cnt_d;

  logic             in_range;
  logic [7:0]       idx;
  logic [9:0]       base_w;

  assign char_ready = char_ready_q;
  assign rom_rd     = rom_rd_q;
  assign rom_addr   = rom_addr_q;
  assign col_data   = col_data_q;
  assign col_valid  = col_valid_q;
  assign col_last   = col_last_q;
  assign busy       = busy_q;

  // Map the incoming code to a glyph base address; unsupported codes draw the substitute glyph.
  always_comb begin
    in_range = (char_in >= FIRST_CHAR) && ({1'b0, char_in} < END_CHAR);
    idx      = in_range ? (char_in - FIRST_CHAR) : (SUBST_CHAR - FIRST_CHAR);
    base_w   = {2'b00, idx} * 10'(COLS);
  end

  // Next-state and registered-output logic for the column sequencer.
  always_comb begin
    state_d      = state_q;
    char_ready_d = char_ready_q;
    rom_rd_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    col_data_d   = col_data_q;
    col_valid_d  = col_valid_q;
    col_last_d   = col_last_q;
    busy_d       = busy_q;
    base_d       = base_q;
    col_cnt_d    = col_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      IDLE: begin
        // char_ready comes up one cycle after reset, so nothing is accepted in that first cycle.
        char_ready_d = 1'b1;
        if (char_ready_q && char_valid) begin
          char_ready_d = 1'b0;
          busy_d       = 1'b1;
          base_d       = base_w;
          col_cnt_d    = '0;
          rom_addr_d   = base_w;
          rom_rd_d     = 1'b1;
          state_d      = READ;
        end
      end
      READ: begin
        // ROM latches the address on the falling edge inside this cycle.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        col_data_d  = rom_data;
        col_valid_d = 1'b1;
        col_last_d  = (GAP_COLS == 0) && (col_cnt_q == LAST_COL);
        state_d     = HOLD;
      end
      HOLD: begin
        if (col_ready) begin
          col_valid_d = 1'b0;
          col_last_d  = 1'b0;
          if (col_cnt_q != LAST_COL) begin
            col_cnt_d  = col_cnt_q + CNT_W'(1);
            rom_addr_d = base_q + 10'(col_cnt_q) + 10'd1;
            rom_rd_d   = 1'b1;
            state_d    = READ;
          end else if (GAP_COLS > 0) begin
            gap_cnt_d   = 2'd0;
            col_data_d  = 8'h00;
            col_valid_d = 1'b1;
            col_last_d  = (GAP_COLS == 1);
            state_d     = GAP;
          end else begin
            busy_d       = 1'b0;
            char_ready_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      GAP: begin
        if (col_ready) begin
          if (gap_cnt_q == LAST_GAP) begin
            col_valid_d  = 1'b0;
            col_last_d   = 1'b0;
            busy_d       = 1'b0;
            char_ready_d = 1'b1;
            state_d      = IDLE;
          end else begin
            gap_cnt_d  = gap_cnt_q + 2'd1;
            col_last_d = ((gap_cnt_q + 2'd1) == LAST_GAP);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any character in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      char_ready_q <= 1'b0;
      rom_rd_q     <= 1'b0;
      rom_addr_q   <= 10'd0;
      col_data_q   <= 8'h00;
      col_valid_q  <= 1'b0;
      col_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      base_q       <= 10'd0;
      col_cnt_q    <= '0;
      gap_cnt_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      char_ready_q <= char_ready_d;
      rom_rd_q     <= rom_rd_d;
      rom_addr_q   <= rom_addr_d;
      col_data_q   <= col_data_d;
      col_valid_q  <= col_valid_d;
      col_last_q   <= col_last_d;
      busy_q       <= busy_d;
      base_q       <= base_d;
      col_cnt_q    <= col_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_font_render_ctrl.sv
// Directed bench for font_render_ctrl with a falling-edge font ROM model.
// Checks addresses, column bytes, col_last, stall stability, busy length and reset behaviour.
module tb_font_render_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [9:0] rom_addr;
  logic       rom_rd;
  logic [7:0] rom_data;
  logic [7:0] col_data;
  logic       col_valid;
  logic       col_ready = 1'b0;
  logic       col_last;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  font_render_ctrl dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .col_data(col_data),
    .col_valid(col_valid), .col_ready(col_ready), .col_last(col_last), .busy(busy)
  );

  // Font ROM content: an arbitrary but address-dependent byte.
  function automatic logic [7:0] rom_byte(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'h2A};
  endfunction

  // ROM registers its output on the falling edge; reset clears it.
  always @(negedge clk) begin
    if (rst) rom_data <= 8'h00;
    else if (rom_rd) rom_data <= rom_byte(rom_addr);
  end

  // Monitor state
  logic [9:0] addr_q[$];
  logic [8:0] col_q[$];
  int         acc_q[$];
  int         last_q[$];
  int         busy_cnt = 0, consec_cnt = 0, stall_err = 0, max_addr = 0;
  int         cyc = 0;
  logic       prev_rd = 1'b0, prev_stall = 1'b0;
  logic [8:0] prev_col = 9'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (rom_rd) begin
        addr_q.push_back(rom_addr);
        if (prev_rd) consec_cnt++;
        if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      end
      prev_rd = rom_rd;
      if (busy) busy_cnt++;
      if (prev_stall && (!col_valid || {col_last, col_data} !== prev_col)) stall_err++;
      prev_stall = col_valid && !col_ready;
      prev_col = {col_last, col_data};
      if (col_valid && col_ready) begin
        col_q.push_back({col_last, col_data});
        if (col_last) last_q.push_back(cyc);
      end
      if (char_valid && char_ready) acc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    addr_q.delete();
    col_q.delete();
    acc_q.delete();
    last_q.delete();
    busy_cnt = 0;
    consec_cnt = 0;
    stall_err = 0;
    max_addr = 0;
  endtask

  task automatic accept(input logic [7:0] code, input logic keep, input string tag);
    logic ok = 1'b0;
    char_in = code;
    char_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (char_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!keep) char_valid = 1'b0;
    chk({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_cols(input int n, input int mode);
    int p = 0;
    for (int i = 0; i < 400; i++) begin
      if (col_q.size() >= n && !busy) break;
      col_ready = (mode == 0) ? 1'b1 : ((p % 4 == 0) || (p % 4 == 3));
      p++;
      step();
    end
  endtask

  task automatic wait_valid(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (col_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_valid_wait"}, 32'(ok), 32'd1);
  endtask

  task automatic check_glyph(input string tag, input int base, input int aoff, input int coff);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(addr_q[aoff+i]), 32'(base + i));
      chk($sformatf("%s_col%0d", tag, i), 32'(col_q[coff+i]),
          32'({1'b0, rom_byte(10'(base + i))}));
    end
    chk($sformatf("%s_gap", tag), 32'(col_q[coff+6]), 32'h100);
  endtask

  task automatic render(input logic [7:0] code, input int base, input int mode, input string tag);
    clear_mon();
    col_ready = (mode == 0);
    accept(code, 1'b0, tag);
    wait_cols(7, mode);
    col_ready = 1'b0;
    chk({tag, "_nreads"}, 32'(addr_q.size()), 32'd6);
    chk({tag, "_ncols"}, 32'(col_q.size()), 32'd7);
    check_glyph(tag, base, 0, 0);
    chk({tag, "_consec_rd"}, 32'(consec_cnt), 32'd0);
    chk({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
    chk({tag, "_max_addr"}, 32'(max_addr), 32'(base + 5));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_char_ready", 32'(char_ready), 32'd0);
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_col_data", 32'(col_data), 32'd0);
    chk("rst_col_valid", 32'(col_valid), 32'd0);
    chk("rst_col_last", 32'(col_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_char_ready", 32'(char_ready), 32'd1);

    // 'A' with col_ready high: addresses 198..203, 19 busy cycles
    render(8'h41, 198, 0, "A");
    chk("A_busy_cycles", 32'(busy_cnt), 32'd19);

    // Out-of-range codes render '?' from 186
    render(8'h07, 186, 0, "bel");
    render(8'hFF, 186, 0, "ff");

    // Boundary glyphs
    render(8'h20, 0, 0, "space");
    render(8'h7D, 558, 0, "brace");

    // Backpressure pattern 1,0,0,1
    render(8'h41, 198, 1, "A_bp");

    // Back-to-back "Hi" with char_valid held
    clear_mon();
    col_ready = 1'b1;
    accept(8'h48, 1'b1, "H");
    accept(8'h69, 1'b0, "i");
    wait_cols(14, 0);
    col_ready = 1'b0;
    chk("Hi_ncols", 32'(col_q.size()), 32'd14);
    chk("Hi_nreads", 32'(addr_q.size()), 32'd12);
    check_glyph("H", 240, 0, 0);
    check_glyph("i", 438, 6, 7);
    chk("Hi_naccepts", 32'(acc_q.size()), 32'd2);
    chk("Hi_accept_gap", 32'(acc_q[1] - last_q[0]), 32'd1);
    chk("Hi_consec_rd", 32'(consec_cnt), 32'd0);

    // Reset during HOLD of column 3
    clear_mon();
    col_ready = 1'b0;
    accept(8'h41, 1'b0, "rstA");
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("rstA_c%0d", k));
      col_ready = 1'b1;
      step();
      col_ready = 1'b0;
    end
    wait_valid("rstA_c3");
    chk("rstA_cols_before", 32'(col_q.size()), 32'd3);
    chk("rstA_reads_before", 32'(addr_q.size()), 32'd4);
    chk("rstA_col3_data", 32'(col_data), 32'(rom_byte(10'd201)));
    rst = 1'b1;
    step();
    chk("mid_rst_char_ready", 32'(char_ready), 32'd0);
    chk("mid_rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_col_data", 32'(col_data), 32'd0);
    chk("mid_rst_col_valid", 32'(col_valid), 32'd0);
    chk("mid_rst_col_last", 32'(col_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    chk("mid_rst_low_char_ready", 32'(char_ready), 32'd0);
    step();
    chk("after_rst_char_ready", 32'(char_ready), 32'd1);
    chk("after_rst_no_reads", 32'(addr_q.size()), 32'd4);
    chk("after_rst_no_cols", 32'(col_q.size()), 32'd3);
    chk("after_rst_rom_data", 32'(rom_data), 32'd0);
    render(8'h41, 198, 0, "A_again");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
